// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types, owner codes and arbitration helper for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE   = 2'd1,
    RELEASE = 2'd2
  } state_t;
  typedef logic [1:0] owner_t;
  localparam owner_t OWN_NONE = 2'b00;
  localparam owner_t OWN_I    = 2'b01;
  localparam owner_t OWN_D    = 2'b10;
  localparam int ADDR_W_DEF = 28;
  localparam int LINE_W_DEF = 128;
  localparam int unsigned TIMEOUT_DEF = 1023;
  // rr_d high means D was served last, so I wins the next tie
  function automatic logic pick_d(input logic pend_i, input logic pend_d, input logic fixed, input logic rr_d);
    return pend_d && (!pend_i || fixed || !rr_d);
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: I-cache, D-cache and memory line-port signals of the arbiter
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;
  owner_t            owner;
  logic              err;
  modport master (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata, owner, err
  );
  modport slave (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata, owner, err
  );
endinterface

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: saturating SERVE-cycle counter that flags a transaction timeout
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en && 32'(cnt) < TIMEOUT) cnt <= cnt + 1'b1;
  end
  // fires on the SERVE cycle that would bring the count to TIMEOUT
  assign timeout = (TIMEOUT != 0) && en && (32'(cnt) + 32'd1 >= TIMEOUT);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises I-cache and D-cache line transactions onto one memory port
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          ADDR_W       = ADDR_W_DEF,
  parameter int          LINE_W       = LINE_W_DEF,
  parameter int          FIXED_D_PRIO = 0,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.master bus
);
  state_t            state, state_n;
  owner_t            own;
  logic              rr_d;
  logic              pend_i, pend_d, sel_d, grant, finish, tmo;
  logic [LINE_W-1:0] line;
  logic              mem_read, mem_write, i_ready, d_ready, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata, i_rdata, d_rdata;
  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) wd (
    .clk(clk),
    .rst(rst),
    .clr(grant),
    .en(state == SERVE),
    .timeout(tmo)
  );
  always_comb begin
    pend_i  = bus.i_read;
    pend_d  = bus.d_read | bus.d_write;
    sel_d   = pick_d(pend_i, pend_d, FIXED_D_PRIO != 0, rr_d);
    grant   = (state == IDLE) && (pend_i || pend_d);
    finish  = (state == SERVE) && (bus.mem_ready || tmo);
    line    = bus.mem_ready ? bus.mem_rdata : '0;
    state_n = (state == IDLE)  ? (grant ? SERVE : IDLE) :
              (state == SERVE) ? (finish ? RELEASE : SERVE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      own       <= OWN_NONE;
      rr_d      <= 1'b1;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state   <= state_n;
      i_ready <= finish && own == OWN_I;
      d_ready <= finish && own == OWN_D;
      // a simultaneous D read+write is issued as a write only
      if (grant) begin
        own       <= sel_d ? OWN_D : OWN_I;
        mem_read  <= sel_d ? bus.d_read && !bus.d_write : 1'b1;
        mem_write <= sel_d && bus.d_write;
        mem_addr  <= sel_d ? bus.d_addr : bus.i_addr;
        mem_wdata <= sel_d ? bus.d_wdata : '0;
      end
      if (finish) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        rr_d      <= own == OWN_D;
        if (own == OWN_I) i_rdata <= line;
        if (own == OWN_D) d_rdata <= line;
      end
      if (state == RELEASE) own <= OWN_NONE;
      err <= err | (grant && sel_d && bus.d_read && bus.d_write) |
             (bus.mem_ready && state != SERVE) | (finish && !bus.mem_ready);
    end
  end
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.i_rdata   = i_rdata;
  assign bus.d_rdata   = d_rdata;
  assign bus.i_ready   = i_ready;
  assign bus.d_ready   = d_ready;
  assign bus.owner     = own;
  assign bus.err       = err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of round-robin and fixed-priority arbiter instances
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  localparam logic [127:0] DEAD = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  mem_port_arbiter_if #(.ADDR_W(28), .LINE_W(128)) a ();
  mem_port_arbiter_if #(.ADDR_W(28), .LINE_W(128)) b ();
  mem_port_arbiter #(.ADDR_W(28), .LINE_W(128), .FIXED_D_PRIO(0), .TIMEOUT(8)) dut_rr (
    .clk(clk), .rst(rst), .bus(a)
  );
  mem_port_arbiter #(.ADDR_W(28), .LINE_W(128), .FIXED_D_PRIO(1), .TIMEOUT(8)) dut_fx (
    .clk(clk), .rst(rst), .bus(b)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clr_in();
    {a.i_read, a.d_read, a.d_write, a.mem_ready} = '0;
    {b.i_read, b.d_read, b.d_write, b.mem_ready} = '0;
    a.i_addr = '0; a.d_addr = '0; a.d_wdata = '0; a.mem_rdata = '0;
    b.i_addr = '0; b.d_addr = '0; b.d_wdata = '0; b.mem_rdata = '0;
  endtask
  // request must already be driven in IDLE; grant happens on the next edge
  task automatic txn(input bit s, input owner_t own, input logic rd, input logic wr,
                     input logic [27:0] addr, input logic [127:0] wd, input int lat,
                     input logic [127:0] rdat);
    tick();
    chk("grant_owner", 128'(s ? b.owner : a.owner), 128'(own));
    chk("grant_mem_read", 128'(s ? b.mem_read : a.mem_read), 128'(rd));
    chk("grant_mem_write", 128'(s ? b.mem_write : a.mem_write), 128'(wr));
    chk("grant_mem_addr", 128'(s ? b.mem_addr : a.mem_addr), 128'(addr));
    if (wr) chk("grant_mem_wdata", s ? b.mem_wdata : a.mem_wdata, wd);
    repeat (lat - 1) tick();
    chk("hold_mem_addr", 128'(s ? b.mem_addr : a.mem_addr), 128'(addr));
    if (s) begin b.mem_ready = 1'b1; b.mem_rdata = rdat; end
    else begin a.mem_ready = 1'b1; a.mem_rdata = rdat; end
    tick();
    a.mem_ready = 1'b0;
    b.mem_ready = 1'b0;
    chk("done_i_ready", 128'(s ? b.i_ready : a.i_ready), 128'(own == OWN_I));
    chk("done_d_ready", 128'(s ? b.d_ready : a.d_ready), 128'(own == OWN_D));
    chk("done_rdata", own == OWN_I ? (s ? b.i_rdata : a.i_rdata) : (s ? b.d_rdata : a.d_rdata), rdat);
    chk("done_strobes", 128'(s ? {b.mem_read, b.mem_write} : {a.mem_read, a.mem_write}), 128'(0));
    tick();
    chk("release_owner", 128'(s ? b.owner : a.owner), 128'(OWN_NONE));
    chk("release_ready", 128'(s ? {b.i_ready, b.d_ready} : {a.i_ready, a.d_ready}), 128'(0));
  endtask
  initial begin
    clr_in();
    tick();
    tick();
    chk("rst_ctrl_a", 128'({a.mem_read, a.mem_write, a.i_ready, a.d_ready, a.err, a.owner}), 128'(0));
    chk("rst_data_a", a.i_rdata | a.d_rdata | a.mem_wdata | 128'(a.mem_addr), 128'(0));
    chk("rst_ctrl_b", 128'({b.mem_read, b.mem_write, b.i_ready, b.d_ready, b.err, b.owner}), 128'(0));
    rst = 1'b0;
    a.i_read = 1'b1; a.i_addr = 28'h0000010;
    txn(0, OWN_I, 1'b1, 1'b0, 28'h0000010, '0, 4, DEAD);
    a.i_read = 1'b0;
    chk("i_only_d_rdata", a.d_rdata, 128'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a.i_read = 1'b1; a.i_addr = 28'h0000100;
    a.d_read = 1'b1; a.d_addr = 28'h0000200;
    txn(0, OWN_I, 1'b1, 1'b0, 28'h0000100, '0, 2, 128'h1111);
    txn(0, OWN_D, 1'b1, 1'b0, 28'h0000200, '0, 2, 128'h2222);
    txn(0, OWN_I, 1'b1, 1'b0, 28'h0000100, '0, 3, 128'h3333);
    txn(0, OWN_D, 1'b1, 1'b0, 28'h0000200, '0, 2, 128'h4444);
    a.i_read = 1'b0; a.d_read = 1'b0;
    b.i_read = 1'b1; b.i_addr = 28'h0000060;
    b.d_read = 1'b1; b.d_addr = 28'h0000070;
    txn(1, OWN_D, 1'b1, 1'b0, 28'h0000070, '0, 2, 128'h5555);
    txn(1, OWN_D, 1'b1, 1'b0, 28'h0000070, '0, 2, 128'h6666);
    txn(1, OWN_D, 1'b1, 1'b0, 28'h0000070, '0, 2, 128'h7777);
    b.d_read = 1'b0;
    txn(1, OWN_I, 1'b1, 1'b0, 28'h0000060, '0, 2, 128'h8888);
    b.i_read = 1'b0;
    a.d_write = 1'b1; a.d_addr = 28'h0000020; a.d_wdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    txn(0, OWN_D, 1'b0, 1'b1, 28'h0000020, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 2, '0);
    a.d_write = 1'b0; a.d_read = 1'b1;
    txn(0, OWN_D, 1'b1, 1'b0, 28'h0000020, '0, 3, 128'hCAFE_F00D);
    a.d_read = 1'b0;
    chk("dw_i_rdata_kept", a.i_rdata, 128'h3333);
    a.i_read = 1'b1; a.i_addr = 28'h0000030;
    tick();
    chk("to_grant", 128'({a.mem_read, a.owner}), 128'({1'b1, OWN_I}));
    repeat (7) tick();
    chk("to_before", 128'({a.mem_read, a.err, a.i_ready}), 128'(3'b100));
    tick();
    chk("to_fire", 128'({a.mem_read, a.err, a.i_ready}), 128'(3'b011));
    chk("to_rdata", a.i_rdata, 128'(0));
    a.i_read = 1'b0;
    tick();
    chk("to_release", 128'({a.owner, a.i_ready}), 128'(0));
    a.d_read = 1'b1; a.d_addr = 28'h0000040;
    txn(0, OWN_D, 1'b1, 1'b0, 28'h0000040, '0, 3, 128'h9999);
    a.d_read = 1'b0;
    chk("to_err_sticky", 128'(a.err), 128'(1));
    a.d_read = 1'b1; a.d_addr = 28'h0000050;
    tick();
    chk("rs_grant", 128'(a.mem_read), 128'(1));
    tick();
    rst = 1'b1; a.d_read = 1'b0;
    tick();
    chk("rs_ctrl", 128'({a.mem_read, a.mem_write, a.i_ready, a.d_ready, a.err, a.owner}), 128'(0));
    chk("rs_data", a.d_rdata | a.i_rdata | 128'(a.mem_addr), 128'(0));
    rst = 1'b0;
    tick();
    chk("rs_no_ready", 128'({a.d_ready, a.owner}), 128'(0));
    a.mem_ready = 1'b1;
    tick();
    a.mem_ready = 1'b0;
    chk("idle_mem_ready_err", 128'({a.err, a.d_ready, a.i_ready}), 128'(3'b100));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_cleared", 128'(a.err), 128'(0));
    a.d_read = 1'b1; a.d_write = 1'b1; a.d_addr = 28'h0000060; a.d_wdata = 128'hABCD;
    txn(0, OWN_D, 1'b0, 1'b1, 28'h0000060, 128'hABCD, 2, '0);
    a.d_read = 1'b0; a.d_write = 1'b0;
    chk("rw_both_err", 128'(a.err), 128'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
